// File: rtl/irq_source_conditioner_if.sv
// Wishbone classic slave bus bundle for irq_source_conditioner.
//
// Signals (16-bit word-addressed bus):
//   cyc, stb, we  - cycle, strobe, write enable (master -> slave)
//   adr           - word address                (master -> slave)
//   dat_w         - write data                  (master -> slave)
//   dat_r         - read data                   (slave -> master)
//   ack           - single-cycle acknowledge    (slave -> master)
interface irq_source_conditioner_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/irq_source_conditioner.sv
// Per-source interrupt event conditioner sitting in front of the interrupt controller.
// Each raw asynchronous event line is 2-flop synchronised, debounced against a shared
// threshold, polarity-adjusted, and presented either as a level or as a one-cycle pulse
// on every accepted activation edge. Configuration is through a small Wishbone slave.
//
// Ports:
//   wb_clk_i  - system clock, all state on its rising edge
//   wb_rst_i  - synchronous active-high reset
//   wb        - Wishbone slave (cyc/stb/we/adr/dat_w in, dat_r/ack out)
//   src_i     - raw asynchronous event lines
//   irq_o     - conditioned events to the interrupt controller
//
// Register map (word address):
//   0 RAW (ro)      synchronised inputs
//   1 EDGE_EN       1 = pulse on activation edge, 0 = level
//   2 POLARITY      1 = active-low / falling edge
//   3 DEBOUNCE      shared threshold D; a change must persist D+1 cycles
//   4 ENABLE        per-source output enable
//   5 STATE (ro)    debounced active vector
//   others          read 0, writes ignored, still acked
module irq_source_conditioner #(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned DEBOUNCE_WIDTH = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  irq_source_conditioner_if.slave  wb,
  input  logic [NUM_SOURCES-1:0]   src_i,
  output logic [NUM_SOURCES-1:0]   irq_o
);

  localparam logic [15:0] AdrRaw      = 16'd0;
  localparam logic [15:0] AdrEdgeEn   = 16'd1;
  localparam logic [15:0] AdrPolarity = 16'd2;
  localparam logic [15:0] AdrDebounce = 16'd3;
  localparam logic [15:0] AdrEnable   = 16'd4;
  localparam logic [15:0] AdrState    = 16'd5;

  // Synchroniser and debounce state
  logic [NUM_SOURCES-1:0]    sync1_q, sync2_q;
  logic [NUM_SOURCES-1:0]    stable_q, stable_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q [NUM_SOURCES];
  logic [DEBOUNCE_WIDTH-1:0] cnt_d [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]    prev_active_q, prev_active_d;
  logic [NUM_SOURCES-1:0]    irq_q, irq_d;

  // Configuration registers
  logic [NUM_SOURCES-1:0]    edge_en_q, edge_en_d;
  logic [NUM_SOURCES-1:0]    pol_q, pol_d;
  logic [DEBOUNCE_WIDTH-1:0] deb_q, deb_d;
  logic [NUM_SOURCES-1:0]    en_q, en_d;

  // Bus state
  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;

  logic                   req;
  logic                   wr;
  logic                   wr_edge_en, wr_pol, wr_deb, wr_en;
  logic [NUM_SOURCES-1:0] active;
  logic [15:0]            rdata;
  logic                   unused_dat_w;

  // Only the low bits of the write data are stored; the rest are deliberately dropped.
  assign unused_dat_w = ^wb.dat_w;

  // A request is serviced once; the registered ack blocks a second service of a held strobe.
  assign req        = wb.cyc & wb.stb & ~ack_q;
  assign wr         = req & wb.we;
  assign wr_edge_en = wr & (wb.adr == AdrEdgeEn);
  assign wr_pol     = wr & (wb.adr == AdrPolarity);
  assign wr_deb     = wr & (wb.adr == AdrDebounce);
  assign wr_en      = wr & (wb.adr == AdrEnable);

  assign active = stable_q ^ pol_q;

  // Configuration next state
  always_comb begin
    edge_en_d = edge_en_q;
    pol_d     = pol_q;
    deb_d     = deb_q;
    en_d      = en_q;
    if (wr_edge_en) edge_en_d = wb.dat_w[NUM_SOURCES-1:0];
    if (wr_pol)     pol_d     = wb.dat_w[NUM_SOURCES-1:0];
    if (wr_deb)     deb_d     = wb.dat_w[DEBOUNCE_WIDTH-1:0];
    if (wr_en)      en_d      = wb.dat_w[NUM_SOURCES-1:0];
  end

  // Debounce: a differing input must be seen on D+1 consecutive cycles to be accepted.
  // The >= compare lets a lowered threshold take effect on an in-flight count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < int'(NUM_SOURCES); i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= deb_q) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEBOUNCE_WIDTH'(1);
      end
    end
  end

  // Output stage. A polarity or mode write reseeds the edge history with the new active
  // value so the reconfiguration itself never looks like an edge.
  always_comb begin
    prev_active_d = active;
    if (wr_pol || wr_edge_en) begin
      prev_active_d = stable_q ^ pol_d;
    end
    irq_d = en_q & active & ~(edge_en_q & prev_active_q);
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (wb.adr)
      AdrRaw:      rdata[NUM_SOURCES-1:0]    = sync2_q;
      AdrEdgeEn:   rdata[NUM_SOURCES-1:0]    = edge_en_q;
      AdrPolarity: rdata[NUM_SOURCES-1:0]    = pol_q;
      AdrDebounce: rdata[DEBOUNCE_WIDTH-1:0] = deb_q;
      AdrEnable:   rdata[NUM_SOURCES-1:0]    = en_q;
      AdrState:    rdata[NUM_SOURCES-1:0]    = active;
      default:     rdata                     = '0;
    endcase
  end

  always_comb begin
    ack_d = req;
    dat_d = req ? rdata : 16'h0000;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      cnt_q         <= '{default: '0};
      prev_active_q <= '0;
      irq_q         <= '0;
      edge_en_q     <= '0;
      pol_q         <= '0;
      deb_q         <= '0;
      en_q          <= '0;
      ack_q         <= 1'b0;
      dat_q         <= '0;
    end else begin
      sync1_q       <= src_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      prev_active_q <= prev_active_d;
      irq_q         <= irq_d;
      edge_en_q     <= edge_en_d;
      pol_q         <= pol_d;
      deb_q         <= deb_d;
      en_q          <= en_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_irq_source_conditioner.sv
module tb_irq_source_conditioner;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic [N-1:0] irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_source_conditioner_if bus ();

  irq_source_conditioner #(
    .NUM_SOURCES   (N),
    .DEBOUNCE_WIDTH(DW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb      (bus),
    .src_i   (src),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.adr   = '0;
    bus.dat_w = '0;
  endtask

  // Returns in the ack cycle (at its falling clock edge) with the strobe already dropped.
  task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                         output logic [15:0] rdat);
    bit got;
    got  = 0;
    rdat = '0;
    step();
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_w = wdat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        got  = 1;
        rdat = bus.dat_r;
      end
    end
    bus_idle();
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wb_timeout adr=%0d: ack not seen, required within 8 cycles", adr);
    end
  endtask

  task automatic wb_write(input logic [15:0] adr, input logic [15:0] dat);
    logic [15:0] dummy;
    wb_xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_read(input logic [15:0] adr, output logic [15:0] dat);
    wb_xfer(1'b0, adr, 16'h0000, dat);
  endtask

  task automatic settle(input int k);
    repeat (k) step();
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    rst = 1'b1; src = '0; bus_idle();
    settle(3);
    // A strobe during reset is abandoned and never acked
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'd4; bus.dat_w = 16'h000F;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.ack !== 1'b0) begin
        n_fail++; $display("FAIL reset_ack: got %b required 0", bus.ack);
      end
    end
    n_checks++;
    if (irq !== '0 || bus.dat_r !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: irq=%h dat=%h required 0/0", irq, bus.dat_r);
    end
    bus_idle();
    step();
    rst = 1'b0;
    for (int a = 0; a <= 5; a++) begin
      wb_read(16'(a), rd);
      n_checks++;
      if (rd !== 16'h0000) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h required 0000", a, rd);
      end
    end
  endtask

  task automatic test_level_d0();
    logic [15:0] rd;
    wb_write(16'd4, 16'h000F);
    settle(4);
    step();
    src = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (irq !== ((k == 4) ? 4'b0101 : 4'b0000)) begin
        n_fail++; $display("FAIL level_latency k=%0d: got %b required %b", k, irq,
                           (k == 4) ? 4'b0101 : 4'b0000);
      end
    end
    wb_read(16'd0, rd);
    n_checks++;
    if (rd !== 16'h0005) begin n_fail++; $display("FAIL raw_read: got %h required 0005", rd); end
    wb_read(16'd5, rd);
    n_checks++;
    if (rd !== 16'h0005) begin n_fail++; $display("FAIL state_read: got %h required 0005", rd); end
    src = '0;
    settle(6);
  endtask

  task automatic test_debounce();
    wb_write(16'd3, 16'd10);
    settle(3);
    step();
    src = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      if (k == 8) begin #1; src = 4'b0000; end
      @(negedge clk);
      n_checks++;
      if (irq[0] !== 1'b0) begin
        n_fail++; $display("FAIL glitch k=%0d: got %b required 0", k, irq[0]);
      end
    end
    step();
    src = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      if (k == 12) begin #1; src = 4'b0000; end
      @(negedge clk);
      n_checks++;
      if (irq[0] !== (k >= 14)) begin
        n_fail++; $display("FAIL pulse12 k=%0d: got %b required %b", k, irq[0], (k >= 14));
      end
    end
    settle(20);
    n_checks++;
    if (irq !== '0) begin n_fail++; $display("FAIL pulse12_release: got %b required 0", irq); end
  endtask

  task automatic test_edge_polarity();
    wb_write(16'd3, 16'd0);
    src = 4'b0001;
    settle(6);
    wb_write(16'd1, 16'h0001);
    wb_write(16'd2, 16'h0001);
    settle(4);
    step();
    src = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (irq[0] !== (k == 4)) begin
        n_fail++; $display("FAIL falling_pulse k=%0d: got %b required %b", k, irq[0], (k == 4));
      end
    end
    // Polarity flips with the line held low: neither direction may pulse
    for (int p = 0; p < 2; p++) begin
      wb_write(16'd2, (p == 0) ? 16'h0000 : 16'h0001);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (irq[0] !== 1'b0) begin
          n_fail++; $display("FAIL pol_write%0d k=%0d: got %b required 0", p, k, irq[0]);
        end
      end
    end
    wb_write(16'd1, 16'h0000);
    wb_write(16'd2, 16'h0000);
    settle(4);
  endtask

  task automatic test_enable();
    wb_write(16'd4, 16'h0000);
    src = 4'b1111;
    settle(8);
    @(negedge clk);
    n_checks++;
    if (irq !== 4'b0000) begin n_fail++; $display("FAIL disabled: got %b required 0000", irq); end
    wb_write(16'd4, 16'h000F);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (irq !== 4'b1111) begin n_fail++; $display("FAIL reenable: got %b required 1111", irq); end
    // Re-enabling in edge mode must not replay the already-active level
    wb_write(16'd4, 16'h0000);
    wb_write(16'd1, 16'h000F);
    wb_write(16'd4, 16'h000F);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (irq !== 4'b0000) begin
        n_fail++; $display("FAIL edge_reenable k=%0d: got %b required 0000", k, irq);
      end
    end
    wb_write(16'd1, 16'h0000);
    src = '0;
    settle(6);
  endtask

  task automatic test_bus();
    logic [15:0] rd;
    wb_read(16'd9, rd);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read: got %h required 0000", rd); end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL ack_width: got %b required 0", bus.ack); end
    wb_write(16'd9, 16'hFFFF);
    wb_read(16'd4, rd);
    n_checks++;
    if (rd !== 16'h000F) begin n_fail++; $display("FAIL unmapped_write: got %h required 000F", rd); end
    wb_write(16'd1, 16'hFFFF);
    wb_read(16'd1, rd);
    n_checks++;
    if (rd !== 16'h000F) begin n_fail++; $display("FAIL edge_en_mask: got %h required 000F", rd); end
    wb_write(16'd3, 16'hFFFF);
    wb_read(16'd3, rd);
    n_checks++;
    if (rd !== 16'h00FF) begin n_fail++; $display("FAIL debounce_mask: got %h required 00FF", rd); end
    step();
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 16'd1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.ack !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL held_strobe k=%0d: got %b required %b", k, bus.ack, (k % 2 == 1));
      end
    end
    bus_idle();
    wb_write(16'd1, 16'h0000);
    wb_write(16'd3, 16'h0000);
  endtask

  task automatic test_reset_mid_debounce();
    wb_write(16'd3, 16'd10);
    wb_write(16'd4, 16'h000F);
    settle(4);
    step();
    src = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (irq !== 4'b0000) begin n_fail++; $display("FAIL mid_debounce k=%0d: got %b required 0000", k, irq); end
    end
    step();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'd4; bus.dat_w = 16'h000F;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack: got %b required 1", bus.ack); end
        bus_idle();
      end
      n_checks++;
      if (irq !== ((k == 4) ? 4'b1111 : 4'b0000)) begin
        n_fail++; $display("FAIL post_reset_latency k=%0d: got %b required %b", k, irq,
                           (k == 4) ? 4'b1111 : 4'b0000);
      end
    end
    src = '0;
    settle(6);
  endtask

  // Reference: a change is accepted once the last D+1 synchronised samples all differ from
  // the accepted value; sync2 seen at edge n is the input sampled at edge n-2.
  task automatic test_random_model(input int trial);
    logic [N-1:0] samp [$];
    logic [N-1:0] act_q [$];
    logic [N-1:0] stab, pol, edg, en, exp_irq;
    int d, hold;
    step();
    rst = 1'b1; src = '0;
    settle(2);
    rst = 1'b0;
    d   = $urandom_range(0, 4);
    pol = N'($urandom);
    edg = N'($urandom);
    en  = N'($urandom);
    wb_write(16'd3, 16'(d));
    wb_write(16'd2, 16'(pol));
    wb_write(16'd1, 16'(edg));
    wb_write(16'd4, 16'(en));
    settle(d + 6);
    stab = '0;
    for (int k = 0; k < d + 3; k++) samp.push_back('0);
    act_q.push_back(pol);
    act_q.push_back(pol);
    hold = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      samp.push_back(src);
      for (int i = 0; i < int'(N); i++) begin
        bit last_on, before_on, all_diff;
        last_on   = act_q[act_q.size()-1][i];
        before_on = act_q[act_q.size()-2][i];
        if (!en[i])       exp_irq[i] = 1'b0;
        else if (edg[i])  exp_irq[i] = last_on && !before_on;
        else              exp_irq[i] = last_on;
        all_diff = 1;
        for (int k = 0; k <= d; k++) begin
          if (samp[samp.size()-3-k][i] == stab[i]) all_diff = 0;
        end
        if (all_diff) stab[i] = ~stab[i];
      end
      act_q.push_back(stab ^ pol);
      #1;
      if (hold == 0) begin
        src  = N'($urandom);
        hold = $urandom_range(1, 2 * d + 4);
      end else begin
        hold--;
      end
      @(negedge clk);
      n_checks++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL random t%0d c=%0d (D=%0d pol=%b edge=%b en=%b): got %b required %b",
                 trial, c, d, pol, edg, en, irq, exp_irq);
      end
    end
    src = '0;
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_level_d0();
    test_debounce();
    test_edge_polarity();
    test_enable();
    test_bus();
    test_reset_mid_debounce();
    for (int t = 0; t < 4; t++) test_random_model(t);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
